mem_access_ctrl: RTL

MEM-stage data-memory initiator for the five-stage MIPS pipeline. It takes the already alignment-checked load/store from the MEM stage and drives the SRAM-like data bus (req/addr_ok/data_ok). It holds the pipeline with a stall request until the access completes, then returns the extended load result. The alignment checker feeds its exception flag in; this block executes only accesses that checker let through.

---
 rtl/mem_access_ctrl_pkg.sv | 26 ++
 rtl/mem_access_ctrl_load_data_ext.sv | 20 ++
 rtl/mem_access_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared EXE op codes, access FSM states and bus size codes
package mem_access_ctrl_pkg;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} accState_t;
  function automatic logic isStore(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction
  function automatic logic [1:0] opSize(input logic [7:0] op);
    return (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) ? SIZE_BYTE :
           (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) ? SIZE_HALF : SIZE_WORD;
  endfunction
  // sub-word stores are replicated so the slave can pick any lane by addr[1:0]
  function automatic logic [31:0] storeData(input logic [7:0] op, input logic [31:0] w);
    return op == EXE_SB_OP ? {4{w[7:0]}} : op == EXE_SH_OP ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_load_data_ext.sv
// load_data_ext: picks the addressed byte/half of a read word and sign/zero-extends it
module load_data_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [7:0]  op,
  output logic [31:0] result
);
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  always_comb begin
    byteSel = rdata[{addrLo, 3'b000} +: 8];
    halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
    result  = op == EXE_LB_OP  ? {{24{byteSel[7]}}, byteSel} :
              op == EXE_LBU_OP ? {24'b0, byteSel} :
              op == EXE_LH_OP  ? {{16{halfSel[15]}}, halfSel} :
              op == EXE_LHU_OP ? {16'b0, halfSel} : rdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data bus initiator (req/addr_ok/data_ok) with pipeline stall.
// Define MEM_ACC_TIMEOUT_EN to abort stuck accesses after TIMEOUT_CYCLES with bus_errM.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        memenM,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        exceptM,
  input  logic        flushM,
  input  logic        stall_other,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok,
  output logic        stall_mem,
  output logic [31:0] rdataM,
  output logic        bus_errM
);
  accState_t state, nextState;
  logic [7:0]  reqOp;
  logic [31:0] loadResult;
  logic accept, busy, finish, killed, discard, timeout;
  assign accept = memenM & ~exceptM & ~flushM;
  assign busy   = state == ADDR | state == DATA;
  assign killed = discard | flushM;
`ifdef MEM_ACC_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] waitCnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) waitCnt <= '0;
    else waitCnt <= busy ? waitCnt + 1'b1 : '0;
  assign timeout  = busy & ~finish & waitCnt == CntW'(TIMEOUT_CYCLES - 1);
  assign bus_errM = timeout;
`else
  assign timeout  = 1'b0;
  assign bus_errM = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = accept ? ADDR : IDLE;
      ADDR:    nextState = timeout ? IDLE : finish ? (killed ? IDLE : DONE) : data_addr_ok ? DATA : ADDR;
      DATA:    nextState = timeout ? IDLE : finish ? (killed ? IDLE : DONE) : DATA;
      DONE:    nextState = (flushM | ~stall_other) ? IDLE : DONE;
      default: nextState = IDLE;
    endcase
  end
  // stall is combinational so the first MEM cycle of an access already holds the pipe
  always_comb begin
    data_req  = state == ADDR;
    finish    = (state == ADDR & data_addr_ok & data_data_ok) | (state == DATA & data_data_ok);
    stall_mem = (state == IDLE & accept) | (busy & ~timeout);
  end
  load_data_ext u_ext (
    .rdata  (data_rdata),
    .addrLo (data_addr[1:0]),
    .op     (reqOp),
    .result (loadResult)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      data_wr    <= 1'b0;
      data_size  <= SIZE_BYTE;
      data_addr  <= '0;
      data_wdata <= '0;
      reqOp      <= '0;
      discard    <= 1'b0;
      rdataM     <= '0;
    end else begin
      if (state == IDLE & accept) begin
        data_wr    <= isStore(alucontrolM);
        data_size  <= opSize(alucontrolM);
        data_addr  <= addrM;
        data_wdata <= storeData(alucontrolM, wdataM);
        reqOp      <= alucontrolM;
        discard    <= 1'b0;
      end
      // an issued request cannot be withdrawn; remember to drop its result instead
      if (busy & flushM) discard <= 1'b1;
      if (finish & ~killed & ~data_wr) rdataM <= loadResult;
    end
endmodule
